// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Brief    : Shared opcode, ALU-control and main-decoder encodings for the
//            RV32I control decoder.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        alu_op_e     alu_op;
        logic        jump;
    } main_dec_t;

endpackage
`default_nettype wire

// File: rtl/rv_alu_dec.sv
`default_nettype none
// ============================================================================
// Module   : rv_alu_dec
// Brief    : Combinational ALU decoder: ALUOp/funct3/funct7 bits -> ALUControl.
// Revision : 1.0 - initial release
// ============================================================================
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    input  logic       funct7b1,
    input  logic       ss2,
    output alu_ctrl_e  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    3'b100:  alu_control = ss2 ? ALU_XOR : ALU_ADD;
                    3'b001:  alu_control = ss2 ? ALU_SLL : ALU_ADD;
                    3'b101:  alu_control = ss2 ? ALU_SRL : ALU_ADD;
                    default: alu_control = ALU_ADD;
                endcase
                // op[5] distinguishes R-type from I-ALU within ALUOp 10
                if (op5 && funct7b1) begin
                    alu_control = ALU_ADD;
                end
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_decoder
// Brief    : RV32I main + ALU decoder, outputs registered (1-cycle latency).
//            Optional macro RV_CTRL_ILLEGAL_EN adds the IllegalInsn output.
// Revision : 1.0 - initial release
// ============================================================================
module rv_ctrl_decoder
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b1,
    input  logic       SS2,
    output logic       MemWrite,
    output logic       Branch,
    output logic       ALUSrc,
    output logic       RegWrite,
    output logic       Jump,
    output logic [2:0] ALUControl,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc
`ifdef RV_CTRL_ILLEGAL_EN
    ,
    output logic       IllegalInsn
`endif
);

    main_dec_t w_main;
    alu_ctrl_e w_alu_control;
    logic      w_illegal;

    always_comb begin
        w_main = '0;
        case (op)
            OP_LW:   w_main = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1,
                                mem_write: 1'b0, result_src: RES_MEM, branch: 1'b0,
                                alu_op: ALUOP_ADD, jump: 1'b0};
            OP_SW:   w_main = '{reg_write: 1'b0, imm_src: IMM_S, alu_src: 1'b1,
                                mem_write: 1'b1, result_src: RES_ALU, branch: 1'b0,
                                alu_op: ALUOP_ADD, jump: 1'b0};
            OP_R:    w_main = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0,
                                mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0,
                                alu_op: ALUOP_FUNCT, jump: 1'b0};
            OP_BEQ:  w_main = '{reg_write: 1'b0, imm_src: IMM_B, alu_src: 1'b0,
                                mem_write: 1'b0, result_src: RES_ALU, branch: 1'b1,
                                alu_op: ALUOP_SUB, jump: 1'b0};
            OP_IALU: w_main = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1,
                                mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0,
                                alu_op: ALUOP_FUNCT, jump: 1'b0};
            OP_JAL:  w_main = '{reg_write: 1'b1, imm_src: IMM_J, alu_src: 1'b0,
                                mem_write: 1'b0, result_src: RES_PC4, branch: 1'b0,
                                alu_op: ALUOP_ADD, jump: 1'b1};
            default: w_main = '0;
        endcase
    end

    rv_alu_dec u_alu_dec (
        .alu_op      (w_main.alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .funct7b1    (funct7b1),
        .ss2         (SS2),
        .alu_control (w_alu_control)
    );

`ifdef RV_CTRL_ILLEGAL_EN
    logic w_known_op;
    logic w_ext_f3;
    assign w_known_op = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                        (op == OP_BEQ) || (op == OP_IALU) || (op == OP_JAL);
    assign w_ext_f3   = (funct3 == 3'b100) || (funct3 == 3'b001) || (funct3 == 3'b101);
    assign w_illegal  = !w_known_op ||
                        ((op == OP_R) && funct7b1) ||
                        (((op == OP_R) || (op == OP_IALU)) && w_ext_f3 && !SS2);

    always_ff @(posedge clk) begin
        if (reset) begin
            IllegalInsn <= 1'b0;
        end else begin
            IllegalInsn <= w_illegal;
        end
    end
`else
    assign w_illegal = 1'b0;
`endif

    // Illegal instructions must not change architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            MemWrite   <= 1'b0;
            Branch     <= 1'b0;
            ALUSrc     <= 1'b0;
            RegWrite   <= 1'b0;
            Jump       <= 1'b0;
            ALUControl <= 3'b000;
            ResultSrc  <= 2'b00;
            ImmSrc     <= 2'b00;
        end else begin
            MemWrite   <= w_main.mem_write & ~w_illegal;
            Branch     <= w_main.branch    & ~w_illegal;
            ALUSrc     <= w_main.alu_src;
            RegWrite   <= w_main.reg_write & ~w_illegal;
            Jump       <= w_main.jump      & ~w_illegal;
            ALUControl <= w_alu_control;
            ResultSrc  <= w_main.result_src;
            ImmSrc     <= w_main.imm_src;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_ctrl_decoder
// Brief    : Scoreboard testbench for rv_ctrl_decoder with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_ctrl_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       funct7b1 = 1'b0;
    logic       SS2 = 1'b0;
    logic       MemWrite, Branch, ALUSrc, RegWrite, Jump;
    logic [2:0] ALUControl;
    logic [1:0] ResultSrc, ImmSrc;
    logic       illegal_act;

    int checks = 0;
    int errors = 0;

    // {mem_write, branch, alu_src, reg_write, jump, alu_ctrl[2:0], result_src[1:0], imm_src[1:0], illegal}
    logic [12:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    rv_ctrl_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .funct7b1   (funct7b1),
        .SS2        (SS2),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .Jump       (Jump),
        .ALUControl (ALUControl),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc)
`ifdef RV_CTRL_ILLEGAL_EN
        ,
        .IllegalInsn(illegal_act)
`endif
    );

`ifndef RV_CTRL_ILLEGAL_EN
    assign illegal_act = 1'b0;
`endif

    function automatic logic [12:0] model(input logic [6:0] o, input logic [2:0] f3,
                                          input logic b5, input logic b1, input logic s2);
        logic       mw, br, as, rw, jp, ill, is_r, is_i, known, ext;
        logic [1:0] rs, is, aluop;
        logic [2:0] ac;
        logic [2:0] f3map [8];
        f3map = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
        {mw, br, as, rw, jp} = 5'b0;
        rs = 2'd0; is = 2'd0; aluop = 2'd0; ac = 3'd0;
        is_r  = (o == 7'h33);
        is_i  = (o == 7'h13);
        known = 1'b1;
        if (o == 7'h03)      begin rw = 1; as = 1; rs = 2'd1; end
        else if (o == 7'h23) begin as = 1; mw = 1; is = 2'd1; end
        else if (is_r)       begin rw = 1; aluop = 2'd2; end
        else if (o == 7'h63) begin br = 1; is = 2'd2; aluop = 2'd1; end
        else if (is_i)       begin rw = 1; as = 1; aluop = 2'd2; end
        else if (o == 7'h6f) begin rw = 1; jp = 1; is = 2'd3; rs = 2'd2; end
        else known = 1'b0;
        ext = (f3 == 3'd4) || (f3 == 3'd1) || (f3 == 3'd5);
        if (aluop == 2'd1) ac = 3'd1;
        else if (aluop == 2'd2) begin
            ac = f3map[f3];
            if (ext && !s2) ac = 3'd0;
            if (f3 == 3'd0 && is_r && b5) ac = 3'd1;
            if (is_r && b1) ac = 3'd0;
        end
        ill = 1'b0;
`ifdef RV_CTRL_ILLEGAL_EN
        ill = !known || (is_r && b1) || ((is_r || is_i) && ext && !s2);
        if (ill) begin rw = 0; mw = 0; br = 0; jp = 0; end
`endif
        return {mw, br, as, rw, jp, ac, rs, is, ill};
    endfunction

    task automatic drive(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                         input logic b5, input logic b1, input logic s2, input string nm);
        @(negedge clk);
        reset = rst; op = o; funct3 = f3; funct7b5 = b5; funct7b1 = b1; SS2 = s2;
        exp_q.push_back(rst ? 13'd0 : model(o, f3, b5, b1, s2));
        name_q.push_back(nm);
    endtask

    // Monitor: one registered result appears per cycle after each drive
    initial begin
        logic [12:0] e, a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = {MemWrite, Branch, ALUSrc, RegWrite, Jump, ALUControl,
                      ResultSrc, ImmSrc, illegal_act};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: op=%b f3=%b got=%b expected=%b", nm, op, funct3, a, e);
                end
            end
        end
    end

    initial begin
        logic [6:0] ops [8];
        logic [6:0] o;
        logic [5:0] c;
        int         wait_cnt;
        ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h6f, 7'h7f, 7'h00};

        drive(1'b1, 7'h03, 3'd0, 1'b0, 1'b0, 1'b0, "reset");
        drive(1'b0, 7'h03, 3'd0, 1'b0, 1'b0, 1'b0, "lw_after_reset");
        drive(1'b0, 7'h33, 3'd0, 1'b1, 1'b0, 1'b0, "sub");
        drive(1'b0, 7'h13, 3'd0, 1'b1, 1'b0, 1'b0, "addi_no_sub");
        drive(1'b0, 7'h33, 3'd7, 1'b0, 1'b1, 1'b1, "f7b1_override");
        drive(1'b1, 7'h6f, 3'd0, 1'b0, 1'b0, 1'b0, "reset_midstream");

        foreach (ops[k]) begin
            for (int i = 0; i < 64; i++) begin
                c = i[5:0];
                drive(1'b0, ops[k], c[2:0], c[3], c[4], c[5], "sweep");
            end
        end

        for (int i = 0; i < 300; i++) begin
            o = ($urandom_range(0, 1) == 0) ? ops[$urandom_range(0, 5)] : 7'($urandom);
            drive(($urandom_range(0, 19) == 0), o, 3'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), "random");
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
